// File: rtl/ncpu32k_exc_ctrl_if.sv
// ----------------------------------------------------------------------------
// ncpu32k_exc_ctrl_if
//   Pipeline-control handshake bundle between the exception sequencer and
//   the rest of the core.
//
//   Signals
//     flush_o           sequencer -> pipeline  flush request, held until ack
//     flush_ack_i       pipeline  -> sequencer flush complete
//     redirect_valid_o  sequencer -> fetch     redirect target is valid
//     redirect_pc_o     sequencer -> fetch     redirect target address
//     redirect_ready_i  fetch     -> sequencer redirect accepted
//
//   Modports
//     master  the exception sequencer side
//     slave   the pipeline / fetch side
// ----------------------------------------------------------------------------
interface ncpu32k_exc_ctrl_if #(
  parameter int DW = 32
);

  logic          flush_o;
  logic          flush_ack_i;
  logic          redirect_valid_o;
  logic [DW-1:0] redirect_pc_o;
  logic          redirect_ready_i;

  modport master (
    output flush_o,
    output redirect_valid_o,
    output redirect_pc_o,
    input  flush_ack_i,
    input  redirect_ready_i
  );

  modport slave (
    input  flush_o,
    input  redirect_valid_o,
    input  redirect_pc_o,
    output flush_ack_i,
    output redirect_ready_i
  );

endinterface

// File: rtl/ncpu32k_exc_ctrl.sv
// ----------------------------------------------------------------------------
// ncpu32k_exc_ctrl
//   Exception / interrupt sequencer sitting at the commit point, directly
//   upstream of the PSR/MSR register file.
//
//   An event seen at commit (synchronous exception, enabled external IRQ or
//   ERET) is accepted in IDLE, the pipeline is flushed, a single-cycle MSR
//   update is issued, and finally fetch is redirected to the exception
//   vector or to the saved EPC.
//
//   Ports
//     clk, rst_n                    clock, asynchronous active-low reset
//     exc_*_i, eret_i, irq_i        commit-point events
//     exc_pc_i/exc_npc_i/exc_lsa_i  PC, next PC and faulting address
//     msr_psr_i/msr_epsr_i/msr_epc_i current machine-state registers
//     pipe                          flush / redirect handshake bundle
//     busy_o                        commit must stall while set
//     msr_*                         single-cycle MSR write port
// ----------------------------------------------------------------------------
module ncpu32k_exc_ctrl #(
  parameter int          DW           = 32,
  parameter int          PSR_DW       = 10,
  parameter logic [31:0] VECT_SYSCALL = 32'h0000_0008,
  parameter logic [31:0] VECT_IRQ     = 32'h0000_0010,
  parameter logic [31:0] VECT_EINSN   = 32'h0000_0018,
  parameter logic [31:0] VECT_EITM    = 32'h0000_0020,
  parameter logic [31:0] VECT_EDTM    = 32'h0000_0028
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              exc_syscall_i,
  input  logic              exc_einsn_i,
  input  logic              exc_eitm_i,
  input  logic              exc_edtm_i,
  input  logic              eret_i,
  input  logic              irq_i,
  input  logic [DW-1:0]     exc_pc_i,
  input  logic [DW-1:0]     exc_npc_i,
  input  logic [DW-1:0]     exc_lsa_i,

  input  logic [PSR_DW-1:0] msr_psr_i,
  input  logic [PSR_DW-1:0] msr_epsr_i,
  input  logic [DW-1:0]     msr_epc_i,

  ncpu32k_exc_ctrl_if.master pipe,

  output logic              busy_o,

  output logic              msr_syscall_ent,
  output logic [PSR_DW-1:0] msr_epsr_nxt,
  output logic              msr_epsr_we,
  output logic [DW-1:0]     msr_epc_nxt,
  output logic              msr_epc_we,
  output logic [DW-1:0]     msr_elsa_nxt,
  output logic              msr_elsa_we,
  output logic              msr_psr_cc_nxt,
  output logic              msr_psr_cc_we,
  output logic              msr_psr_rm_nxt,
  output logic              msr_psr_rm_we,
  output logic              msr_psr_ire_nxt,
  output logic              msr_psr_ire_we,
  output logic              msr_psr_imme_nxt,
  output logic              msr_psr_imme_we,
  output logic              msr_psr_dmme_nxt,
  output logic              msr_psr_dmme_we
);

  localparam int PSR_CC   = 0;
  localparam int PSR_RM   = 4;
  localparam int PSR_IRE  = 5;
  localparam int PSR_IMME = 6;
  localparam int PSR_DMME = 7;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_FLUSH  = 2'd1,
    S_COMMIT = 2'd2,
    S_REDIR  = 2'd3
  } state_t;

  typedef enum logic [2:0] {
    CAUSE_NONE    = 3'd0,
    CAUSE_SYSCALL = 3'd1,
    CAUSE_IRQ     = 3'd2,
    CAUSE_EINSN   = 3'd3,
    CAUSE_EITM    = 3'd4,
    CAUSE_EDTM    = 3'd5,
    CAUSE_ERET    = 3'd6
  } cause_t;

  state_t            state;
  state_t            state_nxt;

  cause_t            cause_r;
  logic [PSR_DW-1:0] psr_r;
  logic [DW-1:0]     epc_r;
  logic [DW-1:0]     elsa_r;
  logic              elsa_en_r;
  logic [DW-1:0]     target_r;
  logic              busy_r;

  logic              accept;
  cause_t            cause_sel;
  logic [PSR_DW-1:0] psr_sel;
  logic [DW-1:0]     epc_sel;
  logic [DW-1:0]     elsa_sel;
  logic              elsa_en_sel;
  logic [DW-1:0]     target_sel;
  logic              flush;
  logic              commit;
  logic              redir_valid;
  logic              any_sync;
  logic              is_eret;

  assign any_sync = exc_edtm_i | exc_eitm_i | exc_einsn_i | exc_syscall_i;

  // State register. An asynchronous reset abandons any sequence in flight;
  // because every MSR write and the redirect are decoded from this state,
  // nothing is written or redirected after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic, event arbitration and per-state control decode.
  // Arbitration only happens in IDLE, so events (including irq_i) are
  // simply ignored while the sequencer is busy. A synchronous exception
  // always beats ERET, and the IRQ yields to both, so the IRQ branch also
  // requires that no ERET is present.
  always_comb begin
    state_nxt   = state;
    accept      = 1'b0;
    cause_sel   = CAUSE_NONE;
    psr_sel     = msr_psr_i;
    epc_sel     = exc_pc_i;
    elsa_sel    = exc_pc_i;
    elsa_en_sel = 1'b0;
    target_sel  = VECT_SYSCALL;
    flush       = 1'b0;
    commit      = 1'b0;
    redir_valid = 1'b0;

    case (state)
      S_IDLE: begin
        if (exc_edtm_i) begin
          accept      = 1'b1;
          cause_sel   = CAUSE_EDTM;
          elsa_sel    = exc_lsa_i;
          elsa_en_sel = 1'b1;
          target_sel  = VECT_EDTM;
        end else if (exc_eitm_i) begin
          accept      = 1'b1;
          cause_sel   = CAUSE_EITM;
          elsa_sel    = exc_pc_i;
          elsa_en_sel = 1'b1;
          target_sel  = VECT_EITM;
        end else if (exc_einsn_i) begin
          accept      = 1'b1;
          cause_sel   = CAUSE_EINSN;
          target_sel  = VECT_EINSN;
        end else if (exc_syscall_i) begin
          accept      = 1'b1;
          cause_sel   = CAUSE_SYSCALL;
          epc_sel     = exc_npc_i;
          target_sel  = VECT_SYSCALL;
        end else if (irq_i && msr_psr_i[PSR_IRE] && !eret_i) begin
          accept      = 1'b1;
          cause_sel   = CAUSE_IRQ;
          target_sel  = VECT_IRQ;
        end else if (eret_i && !any_sync) begin
          accept      = 1'b1;
          cause_sel   = CAUSE_ERET;
          psr_sel     = msr_epsr_i;
          epc_sel     = msr_epc_i;
          target_sel  = msr_epc_i;
        end
        if (accept) begin
          state_nxt = S_FLUSH;
        end
      end

      S_FLUSH: begin
        flush = 1'b1;
        if (pipe.flush_ack_i) begin
          state_nxt = S_COMMIT;
        end
      end

      S_COMMIT: begin
        commit    = 1'b1;
        state_nxt = S_REDIR;
      end

      S_REDIR: begin
        redir_valid = 1'b1;
        if (pipe.redirect_ready_i) begin
          state_nxt = S_IDLE;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Capture registers, loaded once at acceptance and held for the rest of
  // the sequence. For ERET the PSR snapshot holds the saved EPSR, which is
  // what gets restored in COMMIT, and the target is the saved EPC.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cause_r   <= CAUSE_NONE;
      psr_r     <= '0;
      epc_r     <= '0;
      elsa_r    <= '0;
      elsa_en_r <= 1'b0;
      target_r  <= '0;
    end else if (accept) begin
      cause_r   <= cause_sel;
      psr_r     <= psr_sel;
      epc_r     <= epc_sel;
      elsa_r    <= elsa_sel;
      elsa_en_r <= elsa_en_sel;
      target_r  <= target_sel;
    end
  end

  // Busy flag kept in its own flop so that the stall seen by commit is a
  // clean register output rather than a decode of the state vector.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= (state_nxt != S_IDLE);
    end
  end

  assign busy_o  = busy_r;
  assign is_eret = (cause_r == CAUSE_ERET);

  assign pipe.flush_o          = flush;
  assign pipe.redirect_valid_o = redir_valid;
  assign pipe.redirect_pc_o    = target_r;

  assign msr_syscall_ent = commit & ~is_eret;
  assign msr_epsr_we     = commit & ~is_eret;
  assign msr_epc_we      = commit & ~is_eret;
  assign msr_elsa_we     = commit & ~is_eret & elsa_en_r;
  assign msr_epsr_nxt    = psr_r;
  assign msr_epc_nxt     = epc_r;
  assign msr_elsa_nxt    = elsa_r;

  assign msr_psr_cc_we    = commit & is_eret;
  assign msr_psr_rm_we    = commit & is_eret;
  assign msr_psr_ire_we   = commit & is_eret;
  assign msr_psr_imme_we  = commit & is_eret;
  assign msr_psr_dmme_we  = commit & is_eret;
  assign msr_psr_cc_nxt   = psr_r[PSR_CC];
  assign msr_psr_rm_nxt   = psr_r[PSR_RM];
  assign msr_psr_ire_nxt  = psr_r[PSR_IRE];
  assign msr_psr_imme_nxt = psr_r[PSR_IMME];
  assign msr_psr_dmme_nxt = psr_r[PSR_DMME];

endmodule

// File: tb/tb_ncpu32k_exc_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ncpu32k_exc_ctrl
//   Directed bench for the exception sequencer. Inputs change 1 ns after the
//   rising edge and outputs are checked at that same point, well away from
//   the next active edge.
// ----------------------------------------------------------------------------
module tb_ncpu32k_exc_ctrl;

  logic        clk;
  logic        rst_n;
  logic        exc_syscall_i;
  logic        exc_einsn_i;
  logic        exc_eitm_i;
  logic        exc_edtm_i;
  logic        eret_i;
  logic        irq_i;
  logic [31:0] exc_pc_i;
  logic [31:0] exc_npc_i;
  logic [31:0] exc_lsa_i;
  logic [9:0]  msr_psr_i;
  logic [9:0]  msr_epsr_i;
  logic [31:0] msr_epc_i;
  logic        busy_o;
  logic        msr_syscall_ent;
  logic [9:0]  msr_epsr_nxt;
  logic        msr_epsr_we;
  logic [31:0] msr_epc_nxt;
  logic        msr_epc_we;
  logic [31:0] msr_elsa_nxt;
  logic        msr_elsa_we;
  logic        msr_psr_cc_nxt,   msr_psr_cc_we;
  logic        msr_psr_rm_nxt,   msr_psr_rm_we;
  logic        msr_psr_ire_nxt,  msr_psr_ire_we;
  logic        msr_psr_imme_nxt, msr_psr_imme_we;
  logic        msr_psr_dmme_nxt, msr_psr_dmme_we;

  int compared;
  int mismatched;

  ncpu32k_exc_ctrl_if #(.DW(32)) exc_if ();

  ncpu32k_exc_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .exc_syscall_i    (exc_syscall_i),
    .exc_einsn_i      (exc_einsn_i),
    .exc_eitm_i       (exc_eitm_i),
    .exc_edtm_i       (exc_edtm_i),
    .eret_i           (eret_i),
    .irq_i            (irq_i),
    .exc_pc_i         (exc_pc_i),
    .exc_npc_i        (exc_npc_i),
    .exc_lsa_i        (exc_lsa_i),
    .msr_psr_i        (msr_psr_i),
    .msr_epsr_i       (msr_epsr_i),
    .msr_epc_i        (msr_epc_i),
    .pipe             (exc_if),
    .busy_o           (busy_o),
    .msr_syscall_ent  (msr_syscall_ent),
    .msr_epsr_nxt     (msr_epsr_nxt),
    .msr_epsr_we      (msr_epsr_we),
    .msr_epc_nxt      (msr_epc_nxt),
    .msr_epc_we       (msr_epc_we),
    .msr_elsa_nxt     (msr_elsa_nxt),
    .msr_elsa_we      (msr_elsa_we),
    .msr_psr_cc_nxt   (msr_psr_cc_nxt),
    .msr_psr_cc_we    (msr_psr_cc_we),
    .msr_psr_rm_nxt   (msr_psr_rm_nxt),
    .msr_psr_rm_we    (msr_psr_rm_we),
    .msr_psr_ire_nxt  (msr_psr_ire_nxt),
    .msr_psr_ire_we   (msr_psr_ire_we),
    .msr_psr_imme_nxt (msr_psr_imme_nxt),
    .msr_psr_imme_we  (msr_psr_imme_we),
    .msr_psr_dmme_nxt (msr_psr_dmme_nxt),
    .msr_psr_dmme_we  (msr_psr_dmme_we)
  );

  // Free-running 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 ns after the next rising edge.
  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  // Drive the commit-point event inputs; ev = {edtm, eitm, einsn, syscall, irq, eret}.
  task automatic applyStimulus(input logic [5:0] ev, input logic [31:0] pc,
                               input logic [31:0] npc, input logic [31:0] lsa,
                               input logic [9:0] psr, input logic [9:0] epsr,
                               input logic [31:0] epc);
    exc_edtm_i    = ev[5];
    exc_eitm_i    = ev[4];
    exc_einsn_i   = ev[3];
    exc_syscall_i = ev[2];
    irq_i         = ev[1];
    eret_i        = ev[0];
    exc_pc_i      = pc;
    exc_npc_i     = npc;
    exc_lsa_i     = lsa;
    msr_psr_i     = psr;
    msr_epsr_i    = epsr;
    msr_epc_i     = epc;
  endtask

  // One counted comparison with an immediate assertion.
  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Full exception flow with immediate flush ack and redirect ready.
  task automatic runException(input string tag, input logic [5:0] ev,
                              input logic [31:0] pc, input logic [31:0] npc,
                              input logic [31:0] lsa, input logic [9:0] psr,
                              input logic [31:0] exp_epc, input logic exp_elsa_we,
                              input logic [31:0] exp_elsa, input logic [31:0] exp_target);
    applyStimulus(ev, pc, npc, lsa, psr, 10'h000, 32'h0);
    waitCycle();
    applyStimulus(6'b0, 32'h0, 32'h0, 32'h0, psr, 10'h000, 32'h0);
    checkOutput({tag, ".flush"}, 64'(exc_if.flush_o), 64'd1);
    checkOutput({tag, ".busy"}, 64'(busy_o), 64'd1);
    waitCycle();
    checkOutput({tag, ".ent"}, 64'(msr_syscall_ent), 64'd1);
    checkOutput({tag, ".epsr_we"}, 64'(msr_epsr_we), 64'd1);
    checkOutput({tag, ".epsr_nxt"}, 64'(msr_epsr_nxt), 64'(psr));
    checkOutput({tag, ".epc_we"}, 64'(msr_epc_we), 64'd1);
    checkOutput({tag, ".epc_nxt"}, 64'(msr_epc_nxt), 64'(exp_epc));
    checkOutput({tag, ".elsa_we"}, 64'(msr_elsa_we), 64'(exp_elsa_we));
    if (exp_elsa_we)
      checkOutput({tag, ".elsa_nxt"}, 64'(msr_elsa_nxt), 64'(exp_elsa));
    checkOutput({tag, ".psr_we"}, 64'({msr_psr_cc_we, msr_psr_rm_we, msr_psr_ire_we,
                                        msr_psr_imme_we, msr_psr_dmme_we}), 64'd0);
    waitCycle();
    checkOutput({tag, ".redir_valid"}, 64'(exc_if.redirect_valid_o), 64'd1);
    checkOutput({tag, ".redir_pc"}, 64'(exc_if.redirect_pc_o), 64'(exp_target));
    checkOutput({tag, ".ent_after"}, 64'(msr_syscall_ent), 64'd0);
    waitCycle();
    checkOutput({tag, ".idle"}, 64'(busy_o), 64'd0);
    checkOutput({tag, ".redir_done"}, 64'(exc_if.redirect_valid_o), 64'd0);
  endtask

  // Directed test sequence.
  initial begin
    compared   = 0;
    mismatched = 0;

    rst_n                  = 1'b0;
    applyStimulus(6'b111111, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                  10'h3FF, 10'h3FF, 32'hFFFF_FFFF);
    exc_if.flush_ack_i     = 1'b1;
    exc_if.redirect_ready_i = 1'b1;
    waitCycle();
    waitCycle();
    $display("[TB] reset checks");
    checkOutput("rst.busy", 64'(busy_o), 64'd0);
    checkOutput("rst.flush", 64'(exc_if.flush_o), 64'd0);
    checkOutput("rst.redir_valid", 64'(exc_if.redirect_valid_o), 64'd0);
    checkOutput("rst.we", 64'({msr_syscall_ent, msr_epsr_we, msr_epc_we, msr_elsa_we,
                               msr_psr_cc_we, msr_psr_rm_we, msr_psr_ire_we,
                               msr_psr_imme_we, msr_psr_dmme_we}), 64'd0);
    checkOutput("rst.redir_pc", 64'(exc_if.redirect_pc_o), 64'd0);

    applyStimulus(6'b0, 32'h0, 32'h0, 32'h0, 10'h000, 10'h000, 32'h0);
    rst_n = 1'b1;
    waitCycle();
    checkOutput("rst.release_idle", 64'(busy_o), 64'd0);

    $display("[TB] syscall");
    runException("syscall", 6'b000100, 32'h1000, 32'h1004, 32'h0, 10'h0A1,
                 32'h1004, 1'b0, 32'h0, 32'h8);

    $display("[TB] edtm priority");
    runException("edtm", 6'b100110, 32'h2000, 32'h2004, 32'hDEAD_BEEF, 10'h020,
                 32'h2000, 1'b1, 32'hDEAD_BEEF, 32'h28);

    $display("[TB] eitm");
    runException("eitm", 6'b010000, 32'h5000, 32'h5004, 32'h1234, 10'h0C0,
                 32'h5000, 1'b1, 32'h5000, 32'h20);

    $display("[TB] einsn beats eret");
    applyStimulus(6'b0, 32'h0, 32'h0, 32'h0, 10'h000, 10'h091, 32'h3000);
    runException("einsn_eret", 6'b001001, 32'h9000, 32'h9004, 32'h0, 10'h0A1,
                 32'h9000, 1'b0, 32'h0, 32'h18);

    $display("[TB] masked irq");
    applyStimulus(6'b000010, 32'h4000, 32'h4004, 32'h0, 10'h000, 10'h000, 32'h0);
    for (int i = 0; i < 3; i++) begin
      waitCycle();
      checkOutput("irq_masked.busy", 64'(busy_o), 64'd0);
      checkOutput("irq_masked.flush", 64'(exc_if.flush_o), 64'd0);
    end

    $display("[TB] enabled irq");
    runException("irq", 6'b000010, 32'h4000, 32'h4004, 32'h0, 10'h020,
                 32'h4000, 1'b0, 32'h0, 32'h10);

    $display("[TB] eret");
    applyStimulus(6'b000001, 32'h7700, 32'h7704, 32'h0, 10'h0A1, 10'h091, 32'h3000);
    waitCycle();
    applyStimulus(6'b0, 32'h0, 32'h0, 32'h0, 10'h0A1, 10'h000, 32'h0);
    checkOutput("eret.flush", 64'(exc_if.flush_o), 64'd1);
    waitCycle();
    checkOutput("eret.psr_nxt", 64'({msr_psr_cc_nxt, msr_psr_rm_nxt, msr_psr_ire_nxt,
                                      msr_psr_imme_nxt, msr_psr_dmme_nxt}), 64'b11001);
    checkOutput("eret.psr_we", 64'({msr_psr_cc_we, msr_psr_rm_we, msr_psr_ire_we,
                                     msr_psr_imme_we, msr_psr_dmme_we}), 64'b11111);
    checkOutput("eret.ent", 64'(msr_syscall_ent), 64'd0);
    checkOutput("eret.exc_we", 64'({msr_epsr_we, msr_epc_we, msr_elsa_we}), 64'd0);
    waitCycle();
    checkOutput("eret.psr_we_after", 64'({msr_psr_cc_we, msr_psr_rm_we, msr_psr_ire_we,
                                           msr_psr_imme_we, msr_psr_dmme_we}), 64'd0);
    checkOutput("eret.redir_valid", 64'(exc_if.redirect_valid_o), 64'd1);
    checkOutput("eret.redir_pc", 64'(exc_if.redirect_pc_o), 64'h3000);
    waitCycle();
    checkOutput("eret.idle", 64'(busy_o), 64'd0);

    $display("[TB] flush and redirect backpressure");
    exc_if.flush_ack_i      = 1'b0;
    exc_if.redirect_ready_i = 1'b0;
    applyStimulus(6'b000100, 32'h6000, 32'h6004, 32'h0, 10'h0A1, 10'h000, 32'h0);
    waitCycle();
    applyStimulus(6'b100000, 32'h7000, 32'h7004, 32'h1, 10'h0A1, 10'h000, 32'h0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("hold.flush", 64'(exc_if.flush_o), 64'd1);
      checkOutput("hold.no_write", 64'({msr_syscall_ent, msr_epsr_we, msr_epc_we}), 64'd0);
      waitCycle();
    end
    exc_if.flush_ack_i = 1'b1;
    checkOutput("hold.flush_last", 64'(exc_if.flush_o), 64'd1);
    waitCycle();
    checkOutput("hold.ent", 64'(msr_syscall_ent), 64'd1);
    checkOutput("hold.epc_nxt", 64'(msr_epc_nxt), 64'h6004);
    checkOutput("hold.elsa_we", 64'(msr_elsa_we), 64'd0);
    waitCycle();
    for (int i = 0; i < 3; i++) begin
      checkOutput("hold.redir_valid", 64'(exc_if.redirect_valid_o), 64'd1);
      checkOutput("hold.redir_pc", 64'(exc_if.redirect_pc_o), 64'h8);
      waitCycle();
    end
    applyStimulus(6'b0, 32'h0, 32'h0, 32'h0, 10'h0A1, 10'h000, 32'h0);
    exc_if.redirect_ready_i = 1'b1;
    checkOutput("hold.redir_final", 64'(exc_if.redirect_pc_o), 64'h8);
    waitCycle();
    checkOutput("hold.idle", 64'(busy_o), 64'd0);

    $display("[TB] reset abort in flush");
    exc_if.flush_ack_i = 1'b0;
    applyStimulus(6'b000100, 32'h8000, 32'h8004, 32'h0, 10'h0A1, 10'h000, 32'h0);
    waitCycle();
    applyStimulus(6'b0, 32'h0, 32'h0, 32'h0, 10'h0A1, 10'h000, 32'h0);
    checkOutput("abort.flush_before", 64'(exc_if.flush_o), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("abort.busy", 64'(busy_o), 64'd0);
    checkOutput("abort.flush", 64'(exc_if.flush_o), 64'd0);
    rst_n = 1'b1;
    exc_if.flush_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      waitCycle();
      checkOutput("abort.no_write", 64'({msr_syscall_ent, msr_epsr_we, msr_epc_we,
                                          msr_elsa_we}), 64'd0);
      checkOutput("abort.no_redir", 64'(exc_if.redirect_valid_o), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
